// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: two-requester round-robin front end for a 4-bit iterative multiply/divide unit
module muldiv_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_hi,
  output logic [3:0] rsp_lo,
  output logic       rsp_err,
  output logic       mux_sel,
  output logic       mux_enable,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next;
  logic last, grant, take, op_r, sel_op, ge;
  logic [3:0] a_r, b_r, hi, lo, sel_a, sel_b;
  logic [1:0] cnt;
  logic [4:0] sum, rem, diff;
  always_comb begin
    grant = (req0_valid && req1_valid) ? ~last : req1_valid;
    take = state == IDLE && (req0_valid || req1_valid);
    sel_op = grant ? req1_op : req0_op;
    sel_a = grant ? req1_a : req0_a;
    sel_b = grant ? req1_b : req0_b;
    next = state == IDLE ? (take ? RUN : IDLE) :
           state == RUN  ? (cnt == 2'd3 ? DONE : RUN) :
           (rsp_ready ? IDLE : DONE);
  end
  // multiply: {hi,lo} shifts right with hi accumulating a; divide: hi is the remainder, lo shifts in quotient bits
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, a_r} : 5'd0);
    rem = {hi, lo[3]};
    diff = rem - {1'b0, b_r};
    ge = rem >= {1'b0, b_r};
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      last <= 1'b1;
      cnt <= '0;
      op_r <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      hi <= '0;
      lo <= '0;
      rsp_id <= 1'b0;
      rsp_err <= 1'b0;
    end else if (take) begin
      last <= grant;
      rsp_id <= grant;
      op_r <= sel_op;
      a_r <= sel_a;
      b_r <= sel_b;
      cnt <= '0;
      hi <= '0;
      lo <= sel_op ? sel_a : sel_b;
      rsp_err <= sel_op && sel_b == 4'd0;
    end else if (state == RUN) begin
      cnt <= cnt + 2'd1;
      hi <= op_r ? (ge ? diff[3:0] : rem[3:0]) : sum[4:1];
      lo <= op_r ? {lo[2:0], ge} : {sum[0], lo[3:1]};
    end
  assign rsp_valid = state == DONE;
  assign busy = state != IDLE;
  assign mux_enable = state == RUN;
  assign mux_sel = state == IDLE ? grant : rsp_id;
  assign req0_ready = !reset && state == IDLE && req0_valid && !grant;
  assign req1_ready = !reset && state == IDLE && req1_valid && grant;
  assign rsp_hi = hi;
  assign rsp_lo = lo;
endmodule
